// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
// Frame: LEN_LO, LEN_HI, 4*N data bytes, XOR checksum byte.
package imem_boot_loader_pkg;

    localparam int LEN_W = 16;
    localparam int CPU_W = 32;

    localparam logic [2:0] BOOT_ST_IDLE   = 3'd0;
    localparam logic [2:0] BOOT_ST_LEN_LO = 3'd1;
    localparam logic [2:0] BOOT_ST_LEN_HI = 3'd2;
    localparam logic [2:0] BOOT_ST_DATA   = 3'd3;
    localparam logic [2:0] BOOT_ST_CSUM   = 3'd4;
    localparam logic [2:0] BOOT_ST_DONE   = 3'd5;
    localparam logic [2:0] BOOT_ST_ERR    = 3'd6;

    function automatic logic st_rx(input logic [2:0] st);
        return (st == BOOT_ST_LEN_LO) || (st == BOOT_ST_LEN_HI) ||
               (st == BOOT_ST_DATA)   || (st == BOOT_ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel feeding the boot loader.
// master = byte source, slave = loader.
interface imem_boot_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/imem_boot_loader_packer.sv
// Little-endian byte-to-word packer with a registered
// one-cycle instruction-memory write strobe.
module boot_word_packer
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    output logic              word_fire,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [CPU_W-1:0]  imem_wdata,
    output logic [ADDR_W:0]   word_idx
);

    logic [1:0]  bidx;
    logic [23:0] shreg;

    assign word_fire = byte_vld & (bidx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx       <= '0;
            shreg      <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (clr) begin
                bidx     <= '0;
                shreg    <= '0;
                word_idx <= '0;
            end else if (byte_vld) begin
                bidx <= bidx + 2'd1;
                if (bidx == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_waddr <= word_idx[ADDR_W-1:0];
                    imem_wdata <= {byte_in, shreg};
                    word_idx   <= word_idx + 1'b1;
                end else begin
                    // earlier bytes slide down toward bit 0
                    shreg <= {byte_in, shreg[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: writes a length/checksum framed image into
// instruction memory and holds the core in reset until verified.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.slave   bs,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_waddr,
    output logic [CPU_W-1:0]    imem_wdata,
    output logic                cpu_rstn,
    output logic                done,
    output logic                err,
    output logic [LEN_W-1:0]    words_loaded
);

    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(2**ADDR_W);

    logic [2:0]       state;
    logic [LEN_W-1:0] len;
    logic [7:0]       csum;
    logic             xfer;
    logic             start_ok;
    logic             byte_vld;
    logic             word_fire;
    logic             last_word;
    logic             len_bad;
    logic [LEN_W-1:0] n_hdr;
    logic [ADDR_W:0]  word_idx;

    assign bs.in_ready = st_rx(state);
    assign xfer        = bs.in_valid & bs.in_ready;
    assign start_ok    = start & ((state == BOOT_ST_IDLE) ||
                                  (state == BOOT_ST_DONE) ||
                                  (state == BOOT_ST_ERR));
    assign byte_vld    = xfer & (state == BOOT_ST_DATA);

    assign n_hdr   = {bs.in_data, len[7:0]};
    assign len_bad = (n_hdr == '0) || ({1'b0, n_hdr} > DEPTH);

    assign words_loaded = LEN_W'(word_idx);
    // word_idx still holds the pre-increment count here
    assign last_word = word_fire &&
                       (words_loaded + LEN_W'(1) == len);

    assign done     = (state == BOOT_ST_DONE);
    assign err      = (state == BOOT_ST_ERR);
    assign cpu_rstn = (state == BOOT_ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT_ST_IDLE;
            len   <= '0;
            csum  <= '0;
        end else if (start_ok) begin
            state <= BOOT_ST_LEN_LO;
            len   <= '0;
            csum  <= '0;
        end else if (xfer) begin
            unique case (state)
                BOOT_ST_LEN_LO: begin
                    len[7:0] <= bs.in_data;
                    state    <= BOOT_ST_LEN_HI;
                end
                BOOT_ST_LEN_HI: begin
                    len   <= n_hdr;
                    state <= len_bad ? BOOT_ST_ERR : BOOT_ST_DATA;
                end
                BOOT_ST_DATA: begin
                    csum <= csum ^ bs.in_data;
                    if (last_word)
                        state <= BOOT_ST_CSUM;
                end
                BOOT_ST_CSUM: begin
                    state <= (bs.in_data == csum) ?
                             BOOT_ST_DONE : BOOT_ST_ERR;
                end
                default: ;
            endcase
        end
    end

    boot_word_packer #(
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .byte_vld   (byte_vld),
        .byte_in    (bs.in_data),
        .word_fire  (word_fire),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .word_idx   (word_idx)
    );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
// Expected writes are queued as bytes are driven.
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rstn;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [7:0]  f1[$];
    logic [7:0]  f2[$];
    logic [7:0]  fh[$];
    logic [7:0]  ck;

    imem_boot_loader_if bif ();

    imem_boot_loader #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bs           (bif),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_rstn     (cpu_rstn),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            chk("we_expected", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) begin
                logic [31:0] a;
                logic [31:0] d;
                a = exp_a.pop_front();
                d = exp_d.pop_front();
                chk("waddr", 32'(imem_waddr), a);
                chk("wdata", imem_wdata, d);
                chk("words_on_we", 32'(words_loaded), a + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        bif.in_valid = 1'b0;
        repeat (gap) tick();
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (bif.in_ready) ok = 1'b1;
            tick();
        end
        bif.in_valid = 1'b0;
        bif.in_data  = 8'($urandom);
        chk("xfer_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] fr[$],
                              input int maxgap,
                              input int nsend,
                              input int start_at);
        int n;
        logic [31:0] w;
        n = 0;
        w = '0;
        for (int i = 0; i < nsend; i++) begin
            if (i == start_at) pulse_start();
            if (i == 1) n = int'({fr[1], fr[0]});
            if (i >= 2 && n > 0 && n <= 1024 && i < 2 + 4 * n) begin
                w = {fr[i], w[31:8]};
                if ((i - 2) % 4 == 3) begin
                    exp_a.push_back(32'((i - 2) / 4));
                    exp_d.push_back(w);
                end
            end
            send_byte(fr[i], int'($urandom_range(0, maxgap)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        f1 = '{8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h0D, 8'h10, 8'h00};
        ck = 8'h00;
        for (int i = 2; i < 10; i++) ck ^= f1[i];
        f2 = f1;
        f1.push_back(ck);
        f2.push_back(8'h0C);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bif.in_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_waddr", 32'(imem_waddr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_rstn", 32'(cpu_rstn), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_words", 32'(words_loaded), 0);
        tick();

        // good image, back-to-back bytes
        pulse_start();
        send_frame(f1, 0, f1.size(), -1);
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_cpu_rstn", 32'(cpu_rstn), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_words", 32'(words_loaded), 2);
        chk("t1_ready_low", 32'(bif.in_ready), 0);
        chk("t1_waddr_hold", 32'(imem_waddr), 1);
        chk("t1_wdata_hold", imem_wdata, 32'h00100D13);
        chk("t1_drained", 32'(exp_a.size()), 0);
        tick();

        // restart from DONE, then bad checksum
        pulse_start();
        @(negedge clk);
        chk("t2_done_clr", 32'(done), 0);
        chk("t2_cpu_rstn_clr", 32'(cpu_rstn), 0);
        chk("t2_words_clr", 32'(words_loaded), 0);
        chk("t2_ready", 32'(bif.in_ready), 1);
        tick();
        send_frame(f2, 0, f2.size(), -1);
        @(negedge clk);
        chk("t2_err", 32'(err), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_cpu_rstn", 32'(cpu_rstn), 0);
        chk("t2_words", 32'(words_loaded), 2);
        chk("t2_drained", 32'(exp_a.size()), 0);
        tick();

        // length header boundaries
        fh = '{8'h00, 8'h00};
        pulse_start();
        send_frame(fh, 0, 2, -1);
        @(negedge clk);
        chk("t3_n0_err", 32'(err), 1);
        chk("t3_n0_words", 32'(words_loaded), 0);
        tick();
        fh = '{8'h01, 8'h04};
        pulse_start();
        send_frame(fh, 0, 2, -1);
        @(negedge clk);
        chk("t3_n401_err", 32'(err), 1);
        tick();
        fh = '{8'h00, 8'h04};
        pulse_start();
        send_frame(fh, 0, 2, -1);
        @(negedge clk);
        chk("t3_n400_err", 32'(err), 0);
        chk("t3_n400_ready", 32'(bif.in_ready), 1);
        tick();
        pulse_rst();

        // gappy stream
        pulse_start();
        send_frame(f1, 2, f1.size(), -1);
        @(negedge clk);
        chk("t4_done", 32'(done), 1);
        chk("t4_words", 32'(words_loaded), 2);
        chk("t4_drained", 32'(exp_a.size()), 0);
        tick();

        // abort after five data bytes, then reload with stray start
        pulse_start();
        send_frame(f1, 1, 7, -1);
        pulse_rst();
        @(negedge clk);
        chk("t5_rst_ready", 32'(bif.in_ready), 0);
        chk("t5_rst_words", 32'(words_loaded), 0);
        chk("t5_rst_waddr", 32'(imem_waddr), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_drained", 32'(exp_a.size()), 0);
        tick();
        pulse_start();
        send_frame(f1, 1, f1.size(), 5);
        @(negedge clk);
        chk("t5_done", 32'(done), 1);
        chk("t5_cpu_rstn", 32'(cpu_rstn), 1);
        chk("t5_words", 32'(words_loaded), 2);
        chk("t5_drained", 32'(exp_a.size()), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
